busy_table: RTL and testbench
=============================

Name: busy_table

Overview:
- Physical-register busy table, directly upstream of the issue slots.
- At dispatch, supplies prs1_busy/prs2_busy for each renamed uop. These bits are loaded into an issue slot's p1/p2 ready logic.
- Marks each dispatched uop's destination pdst busy, and clears busy bits when writeback wakeups arrive on the same wakeup ports the issue slots snoop.
- Keeps the dispatch-time busy view consistent with the slots' own wakeup tracking.

Parameters:
- NUM_PREGS, 128, number of physical registers; p0 is hardwired not-busy.
- PREG_W, 7, physical register index width; must equal clog2(NUM_PREGS).
- DISP_W, 2, dispatch lanes per cycle; lane 0 is oldest.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- io_ren_valid  input  DISP_W  lane carries a renamed uop this cycle
- io_ren_dst_valid  input  DISP_W  lane's uop writes a destination register
- io_ren_pdst  input  DISP_W*PREG_W  lane destination pregs; lane i at bits [i*PREG_W +: PREG_W]
- io_ren_prs1  input  DISP_W*PREG_W  lane source 1 pregs
- io_ren_prs2  input  DISP_W*PREG_W  lane source 2 pregs
- io_prs1_busy  output  DISP_W  source 1 busy for lane i
- io_prs2_busy  output  DISP_W  source 2 busy for lane i
- io_wakeup_ports_0_valid  input  1  writeback wakeup 0
- io_wakeup_ports_0_bits_pdst  input  PREG_W  woken preg
- io_wakeup_ports_1_valid  input  1  writeback wakeup 1
- io_wakeup_ports_1_bits_pdst  input  PREG_W  woken preg
- io_flush  input  1  pipeline flush; all in-flight producers discarded
- io_busy_count  output  PREG_W+1  number of busy pregs, registered

Behaviour:
- State: busy[NUM_PREGS-1:0] register; reset value all 0; io_busy_count reset value 0.
- Reads are combinational, same cycle, from the registered busy bits.
- For each lane i, io_prsX_busy[i] = busy[prsX[i]] OR intra-bundle hit.
- Intra-bundle hit: some older lane j<i has io_ren_valid[j] & io_ren_dst_valid[j] & pdst[j]==prsX[i].
- Outputs for lanes with io_ren_valid=0 are don't-care; the implementation drives them 0.
- prsX==0 always reads 0, including for intra-bundle hits. A lane with pdst==0 never sets busy.
- Next-state, per preg p, in priority order:
  1. reset -> 0.
  2. io_flush -> 0; allocations in the same cycle are ignored.
  3. Allocate: any lane with valid & dst_valid & pdst==p -> 1. Allocation wins over a same-cycle wakeup to the same p, because a new producer is reusing the freed preg.
  4. Wakeup: either port valid & bits_pdst==p -> 0.
  5. Otherwise hold.
- Both wakeup ports naming the same preg: cleared once; no error.
- Two lanes allocating the same pdst is illegal input; the result is busy=1 with no other side effect.
- Wakeup of a preg that is not busy: no effect.
- io_busy_count = popcount of busy after the update; it is registered and therefore follows busy with 1-cycle latency relative to the inputs causing the change.
- Invariant: io_busy_count == popcount(busy) every cycle; never exceeds NUM_PREGS-1.
- Reset mid-operation: next cycle all bits 0 and count 0, regardless of concurrent allocate, wakeup or flush.

Optional Feature:
- Macro: BUSY_TABLE_WAKEUP_BYPASS_EN.
- Defined: a same-cycle wakeup also masks the read. io_prsX_busy[i] is forced 0 when either wakeup port is valid with bits_pdst==prsX[i]. This prevents a dispatched uop from missing a wakeup that its issue slot cannot yet see. The intra-bundle hit still forces 1, because the younger producer has priority.
- Not defined: reads reflect registered state only. The issue slot must catch the wakeup itself.
- Next-state update is identical in both builds.

Test Plan:
- Reset, then lane0 valid, dst_valid, pdst=5 -> next cycle a read of prs1=5 gives busy=1 and io_busy_count=1. Wakeup port0 pdst=5 -> following cycle busy=0, count=0.
- Same cycle: lane0 pdst=9 and lane1 prs2=9 -> io_prs2_busy[1]=1 combinationally. Lane1 prs1=0 -> io_prs1_busy[1]=0.
- Preg 12 busy; same cycle wakeup0 pdst=12 and lane0 allocates pdst=12 -> busy[12]=1 next cycle; count unchanged.
- Preg 20 busy; wakeup1 pdst=20 while lane0 reads prs1=20 -> with BUSY_TABLE_WAKEUP_BYPASS_EN, io_prs1_busy[0]=0; without it, 1. busy[20]=0 next cycle in both builds.
- Allocate pregs 1..10 over 5 cycles (2 lanes each) -> count=10. Assert io_flush while lane0 allocates 11 -> next cycle count=0 and preg 11 not busy.
- Both wakeup ports pdst=3 with preg 3 busy, count=4 -> next cycle busy[3]=0, count=3. Reset asserted mid-sequence -> count=0 and all reads 0.

Source files
------------

// File: rtl/busy_table.sv
`default_nettype none
// ============================================================================
// Module   : busy_table
// Brief    : Physical-register busy table supplying dispatch-time source busy
//            bits. Optional macro BUSY_TABLE_WAKEUP_BYPASS_EN masks reads with
//            same-cycle writeback wakeups.
// Revision : 1.0  initial release
// ============================================================================
module busy_table #(
  parameter int NUM_PREGS = 128,
  parameter int PREG_W    = 7,
  parameter int DISP_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DISP_W-1:0]        io_ren_valid,
  input  logic [DISP_W-1:0]        io_ren_dst_valid,
  input  logic [DISP_W*PREG_W-1:0] io_ren_pdst,
  input  logic [DISP_W*PREG_W-1:0] io_ren_prs1,
  input  logic [DISP_W*PREG_W-1:0] io_ren_prs2,
  output logic [DISP_W-1:0]        io_prs1_busy,
  output logic [DISP_W-1:0]        io_prs2_busy,
  input  logic                     io_wakeup_ports_0_valid,
  input  logic [PREG_W-1:0]        io_wakeup_ports_0_bits_pdst,
  input  logic                     io_wakeup_ports_1_valid,
  input  logic [PREG_W-1:0]        io_wakeup_ports_1_bits_pdst,
  input  logic                     io_flush,
  output logic [PREG_W:0]          io_busy_count
);

  logic [NUM_PREGS-1:0] r_busy;
  logic [NUM_PREGS-1:0] w_busy_next;
  logic [PREG_W:0]      r_busy_count;
  logic [PREG_W:0]      w_count_next;

  // Per-lane source lookup: registered bit OR a producer in an older lane.
  for (genvar i = 0; i < DISP_W; i++) begin : g_lane
    logic [PREG_W-1:0] w_prs1;
    logic [PREG_W-1:0] w_prs2;
    logic              w_hit1;
    logic              w_hit2;
    logic              w_base1;
    logic              w_base2;

    assign w_prs1 = io_ren_prs1[i*PREG_W +: PREG_W];
    assign w_prs2 = io_ren_prs2[i*PREG_W +: PREG_W];

    always_comb begin
      w_hit1 = 1'b0;
      w_hit2 = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (io_ren_valid[j] && io_ren_dst_valid[j]) begin
          if (io_ren_pdst[j*PREG_W +: PREG_W] == w_prs1) w_hit1 = 1'b1;
          if (io_ren_pdst[j*PREG_W +: PREG_W] == w_prs2) w_hit2 = 1'b1;
        end
      end
    end

`ifdef BUSY_TABLE_WAKEUP_BYPASS_EN
    logic w_wake1;
    logic w_wake2;
    assign w_wake1 = (io_wakeup_ports_0_valid && (io_wakeup_ports_0_bits_pdst == w_prs1)) ||
                     (io_wakeup_ports_1_valid && (io_wakeup_ports_1_bits_pdst == w_prs1));
    assign w_wake2 = (io_wakeup_ports_0_valid && (io_wakeup_ports_0_bits_pdst == w_prs2)) ||
                     (io_wakeup_ports_1_valid && (io_wakeup_ports_1_bits_pdst == w_prs2));
    assign w_base1 = r_busy[w_prs1] & ~w_wake1;
    assign w_base2 = r_busy[w_prs2] & ~w_wake2;
`else
    assign w_base1 = r_busy[w_prs1];
    assign w_base2 = r_busy[w_prs2];
`endif

    assign io_prs1_busy[i] = io_ren_valid[i] & (w_prs1 != '0) & (w_base1 | w_hit1);
    assign io_prs2_busy[i] = io_ren_valid[i] & (w_prs2 != '0) & (w_base2 | w_hit2);
  end

  // Allocation is applied after wakeup so a reused preg stays busy.
  always_comb begin
    w_busy_next = r_busy;
    if (io_wakeup_ports_0_valid) w_busy_next[io_wakeup_ports_0_bits_pdst] = 1'b0;
    if (io_wakeup_ports_1_valid) w_busy_next[io_wakeup_ports_1_bits_pdst] = 1'b0;
    for (int i = 0; i < DISP_W; i++) begin
      if (io_ren_valid[i] && io_ren_dst_valid[i])
        w_busy_next[io_ren_pdst[i*PREG_W +: PREG_W]] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
    if (io_flush) w_busy_next = '0;
  end

  always_comb begin
    w_count_next = '0;
    for (int p = 0; p < NUM_PREGS; p++) begin
      w_count_next = w_count_next + (PREG_W+1)'(w_busy_next[p]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      r_busy       <= w_busy_next;
      r_busy_count <= w_count_next;
    end
  end

  assign io_busy_count = r_busy_count;

endmodule
`default_nettype wire

// File: tb/tb_busy_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_busy_table
// Brief    : Directed and random checks of busy_table against an array model.
// Revision : 1.0  initial release
// ============================================================================
module tb_busy_table;
  localparam int NUM_PREGS = 128;
  localparam int PREG_W    = 7;
  localparam int DISP_W    = 2;

  logic                     clk;
  logic                     reset;
  logic [DISP_W-1:0]        ren_valid;
  logic [DISP_W-1:0]        ren_dst_valid;
  logic [DISP_W*PREG_W-1:0] ren_pdst;
  logic [DISP_W*PREG_W-1:0] ren_prs1;
  logic [DISP_W*PREG_W-1:0] ren_prs2;
  logic [DISP_W-1:0]        prs1_busy;
  logic [DISP_W-1:0]        prs2_busy;
  logic                     wk0_v;
  logic [PREG_W-1:0]        wk0_p;
  logic                     wk1_v;
  logic [PREG_W-1:0]        wk1_p;
  logic                     flush;
  logic [PREG_W:0]          busy_count;

  bit model_busy [NUM_PREGS];
  int tests = 0;
  int fails = 0;

  busy_table #(.NUM_PREGS(NUM_PREGS), .PREG_W(PREG_W), .DISP_W(DISP_W)) dut (
    .clk                         (clk),
    .reset                       (reset),
    .io_ren_valid                (ren_valid),
    .io_ren_dst_valid            (ren_dst_valid),
    .io_ren_pdst                 (ren_pdst),
    .io_ren_prs1                 (ren_prs1),
    .io_ren_prs2                 (ren_prs2),
    .io_prs1_busy                (prs1_busy),
    .io_prs2_busy                (prs2_busy),
    .io_wakeup_ports_0_valid     (wk0_v),
    .io_wakeup_ports_0_bits_pdst (wk0_p),
    .io_wakeup_ports_1_valid     (wk1_v),
    .io_wakeup_ports_1_bits_pdst (wk1_p),
    .io_flush                    (flush),
    .io_busy_count               (busy_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int p = 0; p < NUM_PREGS; p++) n += int'(model_busy[p]);
    return n;
  endfunction

  // A source is busy if the table says so or an older lane in the bundle writes it.
  function automatic bit exp_read(input int lane, input logic [PREG_W-1:0] prs);
    bit hit = 1'b0;
    bit base;
    if (prs == 0) return 1'b0;
    for (int j = 0; j < lane; j++)
      if (ren_valid[j] && ren_dst_valid[j] && ren_pdst[j*PREG_W +: PREG_W] == prs) hit = 1'b1;
    base = model_busy[prs];
`ifdef BUSY_TABLE_WAKEUP_BYPASS_EN
    if ((wk0_v && wk0_p == prs) || (wk1_v && wk1_p == prs)) base = 1'b0;
`endif
    return hit | base;
  endfunction

  task automatic idle();
    ren_valid = '0; ren_dst_valid = '0;
    ren_pdst = '0; ren_prs1 = '0; ren_prs2 = '0;
    wk0_v = 1'b0; wk0_p = '0; wk1_v = 1'b0; wk1_p = '0;
    flush = 1'b0;
  endtask

  task automatic set_lane(input int lane, input bit v, input bit dv,
                          input int pd, input int p1, input int p2);
    ren_valid[lane]                   = v;
    ren_dst_valid[lane]               = dv;
    ren_pdst[lane*PREG_W +: PREG_W]   = PREG_W'(pd);
    ren_prs1[lane*PREG_W +: PREG_W]   = PREG_W'(p1);
    ren_prs2[lane*PREG_W +: PREG_W]   = PREG_W'(p2);
  endtask

  // Entered at posedge+1 with inputs driven; checks, updates model, advances one cycle.
  task automatic tick();
    logic [PREG_W-1:0] pd;
    #3;
    check("busy_count", 32'(busy_count), 32'(model_count()));
    for (int i = 0; i < DISP_W; i++) begin
      if (ren_valid[i]) begin
        check($sformatf("prs1_busy_l%0d", i), 32'(prs1_busy[i]),
              32'(exp_read(i, ren_prs1[i*PREG_W +: PREG_W])));
        check($sformatf("prs2_busy_l%0d", i), 32'(prs2_busy[i]),
              32'(exp_read(i, ren_prs2[i*PREG_W +: PREG_W])));
      end
    end
    if (reset || flush) begin
      for (int p = 0; p < NUM_PREGS; p++) model_busy[p] = 1'b0;
    end else begin
      if (wk0_v) model_busy[wk0_p] = 1'b0;
      if (wk1_v) model_busy[wk1_p] = 1'b0;
      for (int i = 0; i < DISP_W; i++) begin
        pd = ren_pdst[i*PREG_W +: PREG_W];
        if (ren_valid[i] && ren_dst_valid[i] && pd != 0) model_busy[pd] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic int rnd_preg();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 15));
    return int'($urandom_range(0, NUM_PREGS-1));
  endfunction

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("reset_count", 32'(busy_count), 32'd0);
    set_lane(0, 1, 0, 0, 5, 100);
    set_lane(1, 1, 0, 0, 127, 1);
    #2;
    check("reset_reads", 32'({prs2_busy, prs1_busy}), 32'd0);
    tick();

    // Allocate then wake preg 5
    idle(); set_lane(0, 1, 1, 5, 0, 0); tick();
    idle(); set_lane(0, 1, 0, 0, 5, 0); #2;
    check("alloc5_busy", 32'(prs1_busy[0]), 32'd1);
    check("alloc5_count", 32'(busy_count), 32'd1);
    tick();
    idle(); wk0_v = 1'b1; wk0_p = 7'd5; tick();
    idle(); set_lane(0, 1, 0, 0, 5, 0); #2;
    check("wake5_busy", 32'(prs1_busy[0]), 32'd0);
    check("wake5_count", 32'(busy_count), 32'd0);
    tick();

    // Intra-bundle forwarding and p0
    do_reset();
    idle(); set_lane(0, 1, 1, 9, 0, 0); set_lane(1, 1, 0, 0, 0, 9); #2;
    check("intra_prs2_l1", 32'(prs2_busy[1]), 32'd1);
    check("intra_p0_l1", 32'(prs1_busy[1]), 32'd0);
    tick();

    // Allocation beats same-cycle wakeup
    do_reset();
    idle(); set_lane(0, 1, 1, 12, 0, 0); tick();
    idle(); wk0_v = 1'b1; wk0_p = 7'd12; set_lane(0, 1, 1, 12, 0, 0); tick();
    idle(); set_lane(0, 1, 0, 0, 12, 0); #2;
    check("realloc12_busy", 32'(prs1_busy[0]), 32'd1);
    check("realloc12_count", 32'(busy_count), 32'd1);
    tick();

    // Read during same-cycle wakeup
    do_reset();
    idle(); set_lane(0, 1, 1, 20, 0, 0); tick();
    idle(); wk1_v = 1'b1; wk1_p = 7'd20; set_lane(0, 1, 0, 0, 20, 0); #2;
`ifdef BUSY_TABLE_WAKEUP_BYPASS_EN
    check("wake20_read", 32'(prs1_busy[0]), 32'd0);
`else
    check("wake20_read", 32'(prs1_busy[0]), 32'd1);
`endif
    tick();
    idle(); set_lane(0, 1, 0, 0, 20, 0); #2;
    check("wake20_after", 32'(prs1_busy[0]), 32'd0);
    check("wake20_count", 32'(busy_count), 32'd0);
    tick();

    // Fill 1..10 then flush with a concurrent allocation
    do_reset();
    for (int k = 0; k < 5; k++) begin
      idle(); set_lane(0, 1, 1, 2*k+1, 0, 0); set_lane(1, 1, 1, 2*k+2, 0, 0); tick();
    end
    idle(); #2;
    check("fill_count", 32'(busy_count), 32'd10);
    flush = 1'b1; set_lane(0, 1, 1, 11, 0, 0); tick();
    idle(); set_lane(0, 1, 0, 0, 11, 1); #2;
    check("flush_count", 32'(busy_count), 32'd0);
    check("flush_read", 32'({prs2_busy[0], prs1_busy[0]}), 32'd0);
    tick();

    // Dual wakeup of one preg, then reset mid-sequence
    do_reset();
    idle(); set_lane(0, 1, 1, 1, 0, 0); set_lane(1, 1, 1, 2, 0, 0); tick();
    idle(); set_lane(0, 1, 1, 3, 0, 0); set_lane(1, 1, 1, 4, 0, 0); tick();
    idle(); wk0_v = 1'b1; wk0_p = 7'd3; wk1_v = 1'b1; wk1_p = 7'd3; #2;
    check("dual_pre_count", 32'(busy_count), 32'd4);
    tick();
    idle(); set_lane(0, 1, 0, 0, 3, 4); #2;
    check("dual_busy3", 32'(prs1_busy[0]), 32'd0);
    check("dual_busy4", 32'(prs2_busy[0]), 32'd1);
    check("dual_count", 32'(busy_count), 32'd3);
    tick();
    idle(); set_lane(0, 1, 1, 5, 0, 0); wk0_v = 1'b1; wk0_p = 7'd1; flush = 1'b1;
    reset = 1'b1; tick();
    reset = 1'b0;
    idle(); set_lane(0, 1, 0, 0, 1, 2); set_lane(1, 1, 0, 0, 4, 5); #2;
    check("midreset_count", 32'(busy_count), 32'd0);
    check("midreset_reads", 32'({prs2_busy, prs1_busy}), 32'd0);
    tick();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      ren_valid     = DISP_W'($urandom);
      ren_dst_valid = DISP_W'($urandom);
      for (int i = 0; i < DISP_W; i++) begin
        ren_pdst[i*PREG_W +: PREG_W] = PREG_W'(rnd_preg());
        ren_prs1[i*PREG_W +: PREG_W] = PREG_W'(rnd_preg());
        ren_prs2[i*PREG_W +: PREG_W] = PREG_W'(rnd_preg());
      end
      wk0_v = ($urandom_range(0, 2) == 0);
      wk0_p = PREG_W'(rnd_preg());
      wk1_v = ($urandom_range(0, 2) == 0);
      wk1_p = PREG_W'(rnd_preg());
      flush = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
